alu_rr_arbiter: RTL
===================

Name: alu_rr_arbiter

Overview:
- Shares the single combinational 8-bit ALU between up to 4 requesters, for example the fetch/branch unit and the execute/lookup unit.
- Round-robin arbitration. Operands are registered, the ALU is driven for exactly one cycle, and the result is registered and returned to the winner over a valid/ready handshake.
- Sits between the requesters and the ALU instance. It is the only driver of the ALU inputs.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4)
- DATA_W, 8, datapath width (fixed to match the ALU; other values are illegal)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_cmd  in  NUM_REQ x 3  ALU opcode per requester
- req_a  in  NUM_REQ x 8  operand A per requester
- req_b  in  NUM_REQ x 8  operand B per requester
- req_sc  in  NUM_REQ  shift-carry in per requester
- resp_valid  out  NUM_REQ  one-hot result valid
- resp_ready  in  NUM_REQ  result accept
- resp_rslt  out  8  result
- resp_sc  out  1  shift-carry out
- resp_zero  out  1  zero flag
- resp_pari  out  1  parity of resp_rslt
- alu_cmd  out  3  to ALU
- alu_a  out  8  to ALU
- alu_b  out  8  to ALU
- alu_sc_i  out  1  to ALU
- alu_rslt  in  8  from ALU
- alu_sc_o  in  1  from ALU
- alu_zero  in  1  from ALU
- grant_cnt  out  NUM_REQ x 8  per-requester grant counters (optional feature)

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, pick the winner by round-robin, searching from (last_grant+1) mod NUM_REQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - On the clock edge: latch cmd, a, b, sc and the winner index; set last_grant to the winner; go to EXEC.
  - If no req_valid is set, stay in IDLE.
- EXEC:
  - alu_* outputs are driven from the latched registers.
  - At the end of the cycle, capture alu_rslt, alu_sc_o and alu_zero into response registers.
  - resp_pari is computed locally as the XOR-reduction of the captured alu_rslt. The ALU parity output is not used.
  - Go to RESP.
- RESP:
  - resp_valid[winner] is 1 and all other resp_valid bits are 0.
  - Response data is stable until the handshake completes.
  - When resp_ready[winner] is 1, go to IDLE on the next edge. No new request is accepted in that same cycle.
  - resp_ready on non-winning bits is ignored.
- In IDLE and RESP, all alu_* outputs are 0.
- Latency:
  - Accept at cycle T, resp_valid at T+2.
  - Minimum 3 cycles per operation.
- req_ready is 0 in EXEC and RESP.
- A requester may drop req_valid before it is granted. It is then not considered for arbitration.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others must hold req_valid.
- last_grant wraps from NUM_REQ-1 to 0.
- Reset (reset_n=0 at a rising edge), including mid-operation:
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - All resp_* = 0 and all alu_* = 0; req_ready = 0 while reset_n is low.
  - Any in-flight operation is dropped without a response.

Optional Feature:
- Macro: ALU_ARB_STATS_EN
- Defined:
  - grant_cnt[i] increments on each accept by requester i and saturates at 255.
  - Cleared by reset.
- Undefined: grant_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum arb_state_t {IDLE, EXEC, RESP}
  - opcode localparams OP_ADD=3'b000, OP_AND=3'b001, OP_XOR=3'b010, OP_BEQ=3'b011, OP_MOV=3'b100, OP_LD=3'b101, OP_ST=3'b110, OP_RTL=3'b111
  - MAX_REQ=4
  - CNT_W=8
- Sub-module rr_picker:
  - Combinational.
  - Inputs: valid vector, last_grant.
  - Outputs: one-hot grant and its index.

Test Plan:
- Single request, ADD: after reset, req 0 issues ADD a=8'h12 b=8'h34 -> req_ready[0] at T, resp_valid[0] at T+2, resp_rslt=8'h46, resp_pari=1.
- Round-robin: req 0 and req 1 both hold valid continuously with resp_ready=1 -> grants alternate 0,1,0,1 (req 0 first), one accept every 3 cycles.
- Backpressure: RTL a=8'h81 b=8'h01, hold resp_ready=0 for 5 cycles -> resp_valid stays 1, resp_rslt=8'h03 stays stable, no new req_ready.
- BEQ zero flag: a=8'h5A b=8'h5A -> resp_zero=1 and resp_rslt=0; then a=8'h5A b=8'h5B -> resp_zero=0 and resp_rslt=8'hFF.
- Reset mid-operation: assert reset_n=0 during EXEC -> next cycle all resp_valid=0 and alu_*=0; after release, requester 0 wins first.
- ALU_ARB_STATS_EN defined: 300 grants to req 1 -> grant_cnt[1]=255 and grant_cnt[0] unchanged. Macro undefined -> grant_cnt=0 throughout.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU round-robin arbiter.
//   arb_state_t  - arbiter FSM state (IDLE -> EXEC -> RESP -> IDLE)
//   OP_*         - 3-bit ALU opcodes as seen on alu_cmd
//   MAX_REQ      - largest supported requester count
//   CNT_W        - width of each per-requester grant counter
//   IDX_W        - width of a requester index
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  localparam logic [2:0] OP_RTL = 3'b111;

  localparam int MAX_REQ = 4;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

endpackage

// File: rtl/alu_rr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   i_valid [NUM_REQ]  pending requests
//   i_last  [IDX_W]    index granted most recently
//   o_grant [NUM_REQ]  one-hot winner (all zero when nothing is pending)
//   o_idx   [IDX_W]    index of the winner
//   o_any              at least one request pending
// The search starts one past i_last and wraps modulo NUM_REQ, so the
// previous winner has the lowest priority.
module rr_picker
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = (int'(i_last) + k) % NUM_REQ;
      // Constant-index scan avoids a variable select wider than the vector.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!o_any && (i == w_cand) && i_valid[i]) begin
          o_any      = 1'b1;
          o_idx      = IDX_W'(i);
          o_grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational 8-bit ALU among NUM_REQ requesters.
// A winner is picked round-robin in IDLE, its operands are registered and
// presented to the ALU for exactly one cycle (EXEC), and the registered
// result is held on the response port until the winner accepts it (RESP).
//   clk, reset_n                  clock, synchronous active-low reset
//   req_valid/req_ready           per-requester request handshake
//   req_cmd/req_a/req_b/req_sc    per-requester opcode and operands
//   resp_valid/resp_ready         per-requester response handshake
//   resp_rslt/sc/zero/pari        shared response data
//   alu_cmd/a/b/sc_i              drive the ALU (zero outside EXEC)
//   alu_rslt/sc_o/zero            ALU results
//   grant_cnt                     per-requester saturating accept counters,
//                                 built only when ALU_ARB_STATS_EN is defined
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][2:0]           req_cmd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_b,
  input  logic [NUM_REQ-1:0]                req_sc,
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic [DATA_W-1:0]                 resp_rslt,
  output logic                              resp_sc,
  output logic                              resp_zero,
  output logic                              resp_pari,
  output logic [2:0]                        alu_cmd,
  output logic [DATA_W-1:0]                 alu_a,
  output logic [DATA_W-1:0]                 alu_b,
  output logic                              alu_sc_i,
  input  logic [DATA_W-1:0]                 alu_rslt,
  input  logic                              alu_sc_o,
  input  logic                              alu_zero,
  output logic [NUM_REQ-1:0][CNT_W-1:0]     grant_cnt
);

  function automatic logic parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == idx) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  arb_state_t          r_state, w_next;
  logic [IDX_W-1:0]    r_last_grant, r_win;
  logic [NUM_REQ-1:0]  w_grant, w_win_oh;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any, w_accept, w_resp_done;

  logic [2:0]          w_sel_cmd;
  logic [DATA_W-1:0]   w_sel_a, w_sel_b;
  logic                w_sel_sc;

  logic [2:0]          r_cmd_p0;
  logic [DATA_W-1:0]   r_a_p0, r_b_p0;
  logic                r_sc_p0;
  logic [DATA_W-1:0]   r_rslt_p1;
  logic                r_sc_p1, r_zero_p1, r_pari_p1;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_valid (req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Accepts are suppressed while reset is asserted so no operand or
  // counter state moves on a reset edge.
  assign w_accept    = (r_state == IDLE) && w_any && reset_n;
  assign w_win_oh    = idx2oh(r_win);
  assign w_resp_done = |(resp_ready & w_win_oh);

  always_comb begin
    w_sel_cmd = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sc  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_cmd = req_cmd[i];
        w_sel_a   = req_a[i];
        w_sel_b   = req_b[i];
        w_sel_sc  = req_sc[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_win        <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last_grant <= w_idx;
        r_win        <= w_idx;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = '0;
    resp_valid = '0;
    resp_rslt  = '0;
    resp_sc    = 1'b0;
    resp_zero  = 1'b0;
    resp_pari  = 1'b0;
    alu_cmd    = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_sc_i   = 1'b0;
    case (r_state)
      IDLE: begin
        if (reset_n) req_ready = w_grant;
        if (w_any) w_next = EXEC;
      end
      EXEC: begin
        alu_cmd  = r_cmd_p0;
        alu_a    = r_a_p0;
        alu_b    = r_b_p0;
        alu_sc_i = r_sc_p0;
        w_next   = RESP;
      end
      RESP: begin
        resp_valid = w_win_oh;
        resp_rslt  = r_rslt_p1;
        resp_sc    = r_sc_p1;
        resp_zero  = r_zero_p1;
        resp_pari  = r_pari_p1;
        if (w_resp_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Stage p0: operands of the accepted request
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd_p0 <= w_sel_cmd;
      r_a_p0   <= w_sel_a;
      r_b_p0   <= w_sel_b;
      r_sc_p0  <= w_sel_sc;
    end
  end

  // Stage p1: ALU result captured at the end of EXEC
  always_ff @(posedge clk) begin
    if (r_state == EXEC) begin
      r_rslt_p1 <= alu_rslt;
      r_sc_p1   <= alu_sc_o;
      r_zero_p1 <= alu_zero;
      r_pari_p1 <= parity(alu_rslt);
    end
  end

`ifdef ALU_ARB_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_REQ-1:0][CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && w_grant[i]) r_cnt[i] <= sat_inc(r_cnt[i]);
      end
    end
  end

  assign grant_cnt = r_cnt;
`else
  assign grant_cnt = '0;
`endif

endmodule
